// File: rtl/mips_mc_core_v2.sv
// mips_mc_core_v2 - multi-cycle MIPS core (lw, sw, R-type, beq, bne, addi, j)
// with a req/ready memory port and a memory-mapped GPIO register.
//
// Ports:
//   clk, reset (async, active low)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : request side of the memory port
//   mem_rdata_i/mem_ready_i                   : response; access completes on a
//                                               rising edge with req & ready
//   gpio_i / gpio_o                           : GPIO in/out, both at GPIO_ADDR
//   state_o                                   : FSM state, for debug
//
// Build option: define MIPS_MC_INSTR_COUNT_EN to add instr_count_o, a retired-
// instruction counter (one tick per return to FETCH).
module mips_mc_core_v2 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int          GPIO_W       = 8,
  parameter logic [31:0] GPIO_ADDR    = 32'h1001_0024
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
`ifdef MIPS_MC_INSTR_COUNT_EN
  output logic [31:0]       instr_count_o,
`endif
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      state, state_d;
  logic [31:0] pc, ir, a, b, mdr, alu_out;
  logic [31:0] rf [32];
  logic [GPIO_W-1:0] gpio;

  logic        req, we;
  logic [31:0] addr;
  logic [31:0] alu_r, diff, simm, gpio_ext;
  logic        is_gpio, take;

  // instruction fields
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};

  assign is_gpio  = (alu_out == GPIO_ADDR);
  assign gpio_ext = 32'(gpio_i);
  assign diff     = a - b;
  assign take     = ((op == OP_BEQ) && (diff == 32'd0)) ||
                    ((op == OP_BNE) && (diff != 32'd0));

  always_comb begin
    alu_r = '0;
    case (funct)
      6'h20:   alu_r = a + b;
      6'h22:   alu_r = a - b;
      6'h24:   alu_r = a & b;
      6'h25:   alu_r = a | b;
      6'h2A:   alu_r = {31'd0, $signed(a) < $signed(b)};
      default: alu_r = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    req     = 1'b0;
    we      = 1'b0;
    addr    = pc;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (mem_ready_i) state_d = DECODE;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEX;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;   // undefined opcode retires as a NOP
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        addr = alu_out;
        if (is_gpio) state_d = MEMWB;
        else begin
          req = 1'b1;
          if (mem_ready_i) state_d = MEMWB;
        end
      end
      MEMWB: state_d = FETCH;
      MEMWR: begin
        addr = alu_out;
        if (is_gpio) state_d = FETCH;
        else begin
          req = 1'b1;
          we  = 1'b1;
          if (mem_ready_i) state_d = FETCH;
        end
      end
      EXEC:    state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Gated by reset so an in-flight request drops the instant reset asserts,
  // even though the state register already reads FETCH.
  assign mem_req_o   = req & reset;
  assign mem_we_o    = we & reset;
  assign mem_addr_o  = addr;
  assign mem_wdata_o = b;
  assign gpio_o      = gpio;
  assign state_o     = state;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VECTOR;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      alu_out <= '0;
      gpio    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      a <= rf[rs];
      b <= rf[rt];
      case (state)
        FETCH: if (mem_ready_i) begin
          ir <= mem_rdata_i;
          pc <= pc + 32'd4;
        end
        DECODE:         alu_out <= pc + {simm[29:0], 2'b00};
        MEMADR, ADDIEX: alu_out <= a + simm;
        MEMRD: begin
          if (is_gpio)          mdr <= gpio_ext;
          else if (mem_ready_i) mdr <= mem_rdata_i;
        end
        MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
        MEMWR:  if (is_gpio) gpio <= b[GPIO_W-1:0];
        EXEC:   alu_out <= alu_r;
        ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
        BRANCH: if (take) pc <= alu_out;
        ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_INSTR_COUNT_EN
  logic [31:0] icount;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     icount <= '0;
    else if ((state != FETCH) && (state_d == FETCH)) icount <= icount + 32'd1;
  end
  assign instr_count_o = icount;
`endif

endmodule

// File: doc/mips_mc_core_v2.md
Name: mips_mc_core_v2

Overview:
- Next-generation multi-cycle MIPS core for the team's single-core SoC.
- Generalised in reset vector, GPIO width and GPIO address.
- Instruction/data memory moves out of the core onto a req/ready handshake, so memory may insert wait states.
- GPIO becomes memory-mapped (input and output ports) instead of a raw ALU-result tap.
- Adds jump (j) and bne alongside lw, sw, R-type, beq and addi.

Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- GPIO_W, 8, width of gpio_o and gpio_i (1..32).
- GPIO_ADDR, 32'h1001_0024, word address decoded as the GPIO register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mem_req_o  output  1  memory access request.
- mem_we_o  output  1  write strobe, qualified by mem_req_o.
- mem_addr_o  output  32  byte address.
- mem_wdata_o  output  32  store data.
- mem_rdata_i  input  32  read data, valid when mem_ready_i=1.
- mem_ready_i  input  1  access completes on the rising edge where mem_req_o=1 and mem_ready_i=1.
- gpio_i  input  GPIO_W  GPIO input port, read via lw GPIO_ADDR.
- gpio_o  output  GPIO_W  GPIO output register, written via sw GPIO_ADDR.
- state_o  output  4  current FSM state encoding, for debug.

Behaviour:
Reset (reset=0, asynchronous):
- PC=RESET_VECTOR; IR, A, B, MDR, ALUOut all 0.
- All 32 registers 0; gpio_o=0; mem_req_o=0, mem_we_o=0; state=FETCH.
- Reset may be asserted at any point, including mid-access; the core abandons the access and the interface sees mem_req_o fall.

Register file:
- $0 always reads 0; writes to it are ignored.
- Read ports are combinational; A and B are captured every cycle.

FSM states and transitions:
- FETCH: mem_req_o=1, mem_we_o=0, addr=PC. Stays in FETCH while mem_ready_i=0. On ready: IR<=mem_rdata_i, PC<=PC+4, go to DECODE.
- DECODE: ALUOut<=PC+(SignImm<<2). Dispatch on opcode:
  - lw/sw -> MEMADR
  - R-type (op 0) -> EXEC
  - beq (4), bne (5) -> BRANCH
  - addi (8) -> ADDIEX
  - j (2) -> JUMP
  - any other opcode -> FETCH (executes as a NOP; PC already advanced).
- MEMADR: ALUOut<=A+SignImm. Go to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - ALUOut==GPIO_ADDR: no request; MDR<=zero-extended gpio_i; one cycle.
  - Otherwise: request at ALUOut; wait for ready; MDR<=mem_rdata_i.
  - Then go to MEMWB.
- MEMWB: rt<=MDR; go to FETCH.
- MEMWR:
  - ALUOut==GPIO_ADDR: gpio_o<=B[GPIO_W-1:0]; no request; one cycle.
  - Otherwise: mem_req_o=1, mem_we_o=1, wdata=B; wait for ready.
  - Then go to FETCH.
- EXEC: ALUOut<=A op B for funct add(0x20), sub(0x22), and(0x24), or(0x25), slt(0x2A, signed). Any other funct gives ALUOut=0 and the write is still performed. Go to ALUWB.
- ALUWB: rd<=ALUOut; go to FETCH.
- BRANCH: compute A-B. If beq and zero, or bne and nonzero, PC<=ALUOut. Go to FETCH.
- ADDIEX: ALUOut<=A+SignImm, 32-bit wrap, no overflow trap. Go to ADDIWB.
- ADDIWB: rt<=ALUOut; go to FETCH.
- JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; go to FETCH.

Latency with mem_ready_i tied to 1:
- lw 5 cycles; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
- Each wait cycle on the memory interface adds 1 cycle.

Handshake rules:
- mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_o=1 and ready is low.
- mem_req_o is 0 in every state other than FETCH, MEMRD and MEMWR.
- mem_ready_i is ignored when mem_req_o=0.
- No unaligned-address checking; mem_addr_o[1:0] is passed through.

Optional Feature:
- Macro: MIPS_MC_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count_o [31:0], reset to 0.
  - Increments by 1 on every transition into FETCH from a completing state, i.e. once per retired instruction, undefined opcodes included.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, ready=1 -> first mem_addr_o=0x0040_0000 with mem_req_o=1; gpio_o=0; state_o=FETCH.
- addi $t0,$0,5; addi $t1,$0,7; add $t2,$t0,$t1; sw $t2,GPIO_ADDR(0-based) -> gpio_o=8'h0C; no mem_req_o during the GPIO store cycle.
- lw from 0x1001_0000 with ready held low for 3 cycles, rdata=0xDEAD_BEEF -> address stable for 4 cycles; lw totals 8 cycles; target register=0xDEAD_BEEF.
- beq $t0,$t0,+2 at 0x0040_0000 -> next fetch at 0x0040_000C. bne with equal operands -> next fetch at 0x0040_0004.
- j 0x0010_0004 at 0x0040_0000 -> next fetch at 0x0040_0010. Undefined opcode 0x3F -> treated as a NOP; next fetch at PC+4.
- reset pulsed low mid-MEMWR wait state -> mem_req_o drops immediately; PC=RESET_VECTOR; gpio_o=0. With MIPS_MC_INSTR_COUNT_EN: 4-instruction program -> instr_count_o=4.
